// File: rtl/adc_pkg.sv
// Shared types and constants for the serial ADC capture block.
// Contents: FSM state enum, frame geometry constants, the decoded result
// struct and a helper that splits a raw 16-bit frame into data + error flag.
package adc_pkg;

   localparam int unsigned FRAME_BITS = 16;
   localparam int unsigned DATA_BITS  = 12;
   localparam int unsigned LEAD_BITS  = 4;
   localparam int unsigned BIT_CNT_W  = $clog2(FRAME_BITS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2,
      GAP  = 2'd3
   } adc_state_e;

   typedef struct packed {
      logic                 frame_err;
      logic [DATA_BITS-1:0] data;
   } adc_result_t;

   // Leading bits of a good frame are all zero; data sits in the low bits.
   function automatic adc_result_t decode_frame(input logic [FRAME_BITS-1:0] frame);
      adc_result_t r;
      r.frame_err = |frame[FRAME_BITS-1 -: LEAD_BITS];
      r.data      = frame[DATA_BITS-1:0];
      return r;
   endfunction

endpackage

// File: rtl/adc_clk_div.sv
// SCLK generator for the ADC serial interface.
// Ports:
//   clk, rst_n  - system clock, async active-low reset
//   run         - high when the next cycle belongs to a conversion frame
//   sclk        - serial clock: CLK_DIV cycles low then CLK_DIV cycles high, idles high
//   sample_tick - high on the last clk cycle of every SCLK high half
module adc_clk_div #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic sclk,
   output logic sample_tick
);

   localparam int unsigned CNT_W = $clog2(CLK_DIV);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             phase_q, phase_d;
   logic             running_q, running_d;
   logic             sclk_q, sclk_d;
   logic             tick_q, tick_d;

   // Next position inside the frame; the first frame cycle always starts a low half.
   always_comb begin
      cnt_d     = '0;
      phase_d   = 1'b0;
      sclk_d    = 1'b1;
      tick_d    = 1'b0;
      running_d = run;
      if (run && running_q) begin
         if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
         end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            phase_d = phase_q;
         end
         sclk_d = phase_d;
         tick_d = phase_d && (cnt_d == CNT_W'(CLK_DIV - 1));
      end else if (run) begin
         sclk_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         phase_q   <= 1'b0;
         running_q <= 1'b0;
         sclk_q    <= 1'b1;
         tick_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         phase_q   <= phase_d;
         running_q <= running_d;
         sclk_q    <= sclk_d;
         tick_q    <= tick_d;
      end
   end

   assign sclk        = sclk_q;
   assign sample_tick = tick_q;

endmodule

// File: rtl/adc_spi_capture.sv
// Continuous capture of 16-bit frames from a serial ADC (4 zero lead bits + 12 data bits).
// Ports:
//   clk, rst_n         - system clock, async active-low reset
//   en                 - keep converting while high; a started frame always completes
//   adc_sdata          - serial data from the ADC, MSB first
//   adc_cs_n, adc_sclk - ADC chip select (low only while converting) and serial clock
//   sample             - last conversion result, with sample_valid strobe
//   frame_err          - last frame had a non-zero lead bit
//   A, B, C, D         - sample[11:8] for the temperature decoder
module adc_spi_capture
   import adc_pkg::*;
#(
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned GAP_CYCLES = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 adc_sdata,
   output logic                 adc_cs_n,
   output logic                 adc_sclk,
   output logic [DATA_BITS-1:0] sample,
   output logic                 sample_valid,
   output logic                 frame_err,
   output logic                 A,
   output logic                 B,
   output logic                 C,
   output logic                 D
);

   localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   adc_state_e              state_q, state_d;
   logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [GAP_W-1:0]        gap_cnt_q, gap_cnt_d;
   logic [FRAME_BITS-1:0]   shift_q, shift_d;
   logic                    sdata_q, sdata_d;
   logic [DATA_BITS-1:0]    sample_q, sample_d;
   logic                    valid_q, valid_d;
   logic                    err_q, err_d;
   logic                    cs_n_q, cs_n_d;
   adc_result_t             res;
   logic                    run_c;
   logic                    tick;

   // Divider looks one cycle ahead so SCLK falls together with CS_N.
   assign run_c = (state_d == CONV);

   adc_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_div (
      .clk         (clk),
      .rst_n       (rst_n),
      .run         (run_c),
      .sclk        (adc_sclk),
      .sample_tick (tick)
   );

   // Next state, counters, shift register and result capture.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      shift_d   = shift_q;
      sdata_d   = adc_sdata;
      sample_d  = sample_q;
      err_d     = err_q;
      valid_d   = 1'b0;
      res       = '0;

      case (state_q)
         IDLE: begin
            if (en) begin
               state_d   = CONV;
               bit_cnt_d = '0;
            end
         end
         CONV: begin
            if (tick) begin
               shift_d = {shift_q[FRAME_BITS-2:0], sdata_q};
               if (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1)) begin
                  state_d = DONE;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
               end
            end
         end
         DONE: begin
            state_d   = GAP;
            gap_cnt_d = '0;
         end
         GAP: begin
            if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
               gap_cnt_d = '0;
               if (en) begin
                  state_d   = CONV;
                  bit_cnt_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      cs_n_d = (state_d != CONV);

      // Result becomes visible, with its strobe, in the DONE cycle itself.
      res = decode_frame(shift_d);
      if (state_d == DONE) begin
         sample_d = res.data;
         err_d    = res.frame_err;
         valid_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         shift_q   <= '0;
         sdata_q   <= 1'b0;
         sample_q  <= '0;
         err_q     <= 1'b0;
         valid_q   <= 1'b0;
         cs_n_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         shift_q   <= shift_d;
         sdata_q   <= sdata_d;
         sample_q  <= sample_d;
         err_q     <= err_d;
         valid_q   <= valid_d;
         cs_n_q    <= cs_n_d;
      end
   end

   assign adc_cs_n     = cs_n_q;
   assign sample       = sample_q;
   assign sample_valid = valid_q;
   assign frame_err    = err_q;
   assign A            = sample_q[11];
   assign B            = sample_q[10];
   assign C            = sample_q[9];
   assign D            = sample_q[8];

endmodule

// File: tb/tb_adc_spi_capture.sv
// Scoreboard bench for adc_spi_capture: one instance at CLK_DIV=2 fed by a
// serial ADC model, one at CLK_DIV=4 for SCLK waveform timing.
module tb_adc_spi_capture;

   localparam int unsigned GAP = 8;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        en        = 1'b0;
   logic        en4       = 1'b0;
   logic        adc_sdata = 1'b0;
   logic        adc_cs_n, adc_sclk, sample_valid, frame_err, A, B, C, D;
   logic [11:0] sample;
   logic        cs4_n, sclk4, valid4, err4, A4, B4, C4, D4;
   logic [11:0] sample4;

   always #5 clk = ~clk;

   adc_spi_capture #(.CLK_DIV(2), .GAP_CYCLES(GAP)) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .adc_sdata(adc_sdata),
      .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .sample(sample),
      .sample_valid(sample_valid), .frame_err(frame_err),
      .A(A), .B(B), .C(C), .D(D)
   );

   adc_spi_capture #(.CLK_DIV(4), .GAP_CYCLES(GAP)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .en(en4), .adc_sdata(1'b1),
      .adc_cs_n(cs4_n), .adc_sclk(sclk4), .sample(sample4),
      .sample_valid(valid4), .frame_err(err4),
      .A(A4), .B(B4), .C(C4), .D(D4)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   logic [15:0] tx_q[$];   // words the ADC model will send
   logic [12:0] sb_q[$];   // expected {frame_err, sample}

   // ADC model: new bit after each SCLK fall, expectation pushed once all 16 bits went out.
   initial begin : drv
      logic [15:0] w;
      forever begin
         @(negedge adc_cs_n);
         w = (tx_q.size() != 0) ? tx_q.pop_front() : 16'h0000;
         for (int i = 15; i >= 0; i--) begin
            adc_sdata = w[i];
            @(posedge adc_sclk or posedge adc_cs_n);
            #1;
            if (adc_cs_n) break;
            if (i == 0) begin
               sb_q.push_back({|w[15:12], w[11:0]});
            end else begin
               @(negedge adc_sclk or posedge adc_cs_n);
               #1;
               if (adc_cs_n) break;
            end
         end
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_valid = 0, n_fall = 0, fall_cyc = 0, rise_cyc = 0;
   bit          gap_on = 1'b0;
   logic        cs_prev = 1'b1, valid_prev = 1'b0;
   logic [11:0] held = '0;
   logic        held_err = 1'b0;

   // Main-DUT monitor: scoreboard compare, latency, gaps, strobe width, output hold.
   always @(negedge clk) begin : mon
      logic [12:0] e;
      if (cs_prev && !adc_cs_n) begin
         if (gap_on) chk("cs_gap", 32'(cyc - rise_cyc), 32'(GAP + 1));
         fall_cyc = cyc;
         n_fall++;
      end
      if (!cs_prev && adc_cs_n) rise_cyc = cyc;
      if (valid_prev && rst_n) chk("valid_width", 32'(sample_valid), 32'd0);
      if (sample_valid) begin
         n_valid++;
         chk("valid_latency", 32'(cyc - fall_cyc), 32'd64);
         chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("sample", 32'(sample), 32'(e[11:0]));
            chk("frame_err", 32'(frame_err), 32'(e[12]));
            chk("abcd", 32'({A, B, C, D}), 32'(e[11:8]));
         end
         held     = sample;
         held_err = frame_err;
      end else if (rst_n) begin
         chk("hold", 32'({frame_err, A, B, C, D, sample}), 32'({held_err, held[11:8], held}));
      end
      if (!rst_n) begin
         held     = '0;
         held_err = 1'b0;
      end
      cs_prev    = adc_cs_n;
      valid_prev = sample_valid;
   end

   int   n_fall4 = 0, n_valid4 = 0, hlen = 0, rises4 = 0;
   logic cs4_prev = 1'b1, sclk4_prev = 1'b1;

   // CLK_DIV=4 monitor: every SCLK half-period and the rising-edge count per frame.
   always @(negedge clk) begin : mon4
      if (cs4_prev && !cs4_n) begin
         hlen   = 1;
         rises4 = 0;
         n_fall4++;
         chk("sclk4_first_low", 32'(sclk4), 32'd0);
      end else if (!cs4_prev && !cs4_n) begin
         if (sclk4 != sclk4_prev) begin
            chk("sclk4_half", 32'(hlen), 32'd4);
            hlen = 1;
            if (sclk4) rises4++;
         end else begin
            hlen++;
         end
      end else if (!cs4_prev && cs4_n) begin
         chk("sclk4_last_half", 32'(hlen), 32'd4);
         chk("sclk4_rises", 32'(rises4), 32'd16);
      end
      if (valid4) begin
         n_valid4++;
         chk("dut4_sample", 32'(sample4), 32'h0FFF);
         chk("dut4_err", 32'(err4), 32'd1);
         chk("dut4_abcd", 32'({A4, B4, C4, D4}), 32'hF);
      end
      cs4_prev   = cs4_n;
      sclk4_prev = sclk4;
   end

   function automatic int get_cnt(input int sel);
      case (sel)
         0:       return n_fall;
         1:       return n_valid;
         2:       return n_fall4;
         default: return n_valid4;
      endcase
   endfunction

   task automatic wait_for(input string tag, input int sel, input int target, input int budget);
      int k = 0;
      while (get_cnt(sel) < target && k < budget) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk(tag, 32'(get_cnt(sel) >= target), 32'd1);
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      settle(3);
      chk("rst_cs_n", 32'(adc_cs_n), 32'd1);
      chk("rst_sclk", 32'(adc_sclk), 32'd1);
      chk("rst_sample", 32'(sample), 32'd0);
      chk("rst_valid", 32'(sample_valid), 32'd0);
      chk("rst_err", 32'(frame_err), 32'd0);
      chk("rst_abcd", 32'({A, B, C, D}), 32'd0);
      chk("rst_cs4_n", 32'(cs4_n), 32'd1);
      chk("rst_sclk4", 32'(sclk4), 32'd1);
      rst_n = 1'b1;

      // 0x0B00 from a short en pulse: exactly one frame
      tx_q.push_back(16'h0B00);
      en = 1'b1;
      wait_for("t1_start", 0, 1, 20);
      en = 1'b0;
      wait_for("t1_valid", 1, 1, 200);
      settle(40);
      chk("t1_frames", 32'(n_fall), 32'd1);
      chk("t1_idle_cs", 32'(adc_cs_n), 32'd1);
      chk("t1_idle_sclk", 32'(adc_sclk), 32'd1);

      // 0xF123 with en dropped at bit 5
      tx_q.push_back(16'hF123);
      en = 1'b1;
      wait_for("t2_start", 0, 2, 20);
      settle(5 * 4);
      en = 1'b0;
      chk("t2_mid_cs", 32'(adc_cs_n), 32'd0);
      wait_for("t2_valid", 1, 2, 200);
      settle(40);
      chk("t2_valids", 32'(n_valid), 32'd2);
      chk("t2_frames", 32'(n_fall), 32'd2);
      chk("t2_idle_cs", 32'(adc_cs_n), 32'd1);
      chk("t2_idle_sclk", 32'(adc_sclk), 32'd1);

      // three back-to-back frames with quiet-time gaps checked
      tx_q.push_back(16'h0ABC);
      tx_q.push_back(16'h0555);
      tx_q.push_back(16'h1FFF);
      en = 1'b1;
      wait_for("t3_start", 0, 3, 20);
      gap_on = 1'b1;
      wait_for("t3_third", 0, 5, 300);
      gap_on = 1'b0;
      en = 1'b0;
      wait_for("t3_valid", 1, 5, 300);
      settle(40);
      chk("t3_valids", 32'(n_valid), 32'd5);
      chk("t3_frames", 32'(n_fall), 32'd5);

      // en dropped during GAP: no further frame
      tx_q.push_back(16'h0777);
      en = 1'b1;
      wait_for("t4_valid", 1, 6, 200);
      en = 1'b0;
      settle(40);
      chk("t4_frames", 32'(n_fall), 32'd6);
      chk("t4_idle_cs", 32'(adc_cs_n), 32'd1);

      // reset at bit 9, then a fresh frame
      tx_q.push_back(16'h0FFF);
      tx_q.push_back(16'h0246);
      en = 1'b1;
      wait_for("t5_start", 0, 7, 20);
      settle(9 * 4);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_cs", 32'(adc_cs_n), 32'd1);
      chk("t5_rst_sclk", 32'(adc_sclk), 32'd1);
      chk("t5_rst_sample", 32'(sample), 32'd0);
      chk("t5_rst_valid", 32'(sample_valid), 32'd0);
      chk("t5_rst_err", 32'(frame_err), 32'd0);
      settle(3);
      rst_n = 1'b1;
      wait_for("t5_restart", 0, 8, 20);
      en = 1'b0;
      wait_for("t5_valid", 1, 7, 200);
      settle(40);
      chk("t5_valids", 32'(n_valid), 32'd7);
      chk("t5_sb_empty", 32'(sb_q.size()), 32'd0);

      // SCLK timing at CLK_DIV=4
      en4 = 1'b1;
      wait_for("t6_start", 2, 1, 20);
      en4 = 1'b0;
      wait_for("t6_valid", 3, 1, 300);
      settle(40);
      chk("t6_valids", 32'(n_valid4), 32'd1);
      chk("t6_idle_sclk4", 32'(sclk4), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/adc_spi_capture.md
ADC_SPI_CAPTURE -- requirements
Module: adc_spi_capture

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clk cycles per SCLK half-period; legal values are >= 2.
REQ-002 SHALL have parameter GAP_CYCLES, default 8, meaning clk cycles with adc_cs_n high between frames (ADC quiet time); legal values are >= 1.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port en, input, 1 bit: run continuous conversions while high.
REQ-006 SHALL have port adc_sdata, input, 1 bit: serial data from the ADC, MSB first.
REQ-007 SHALL have port adc_cs_n, output, 1 bit: ADC chip select, active low.
REQ-008 SHALL have port adc_sclk, output, 1 bit: ADC serial clock; it idles high.
REQ-009 SHALL have port sample, output, 12 bits: last captured conversion result.
REQ-010 SHALL have port sample_valid, output, 1 bit: one-cycle strobe when sample updates.
REQ-011 SHALL have port frame_err, output, 1 bit: set when the last frame's 4 leading bits were not all zero.
REQ-012 SHALL have ports A, B, C, D, output, 1 bit each: sample[11], sample[10], sample[9], sample[8], which feed the temperature decoder.

Function
REQ-013 SHALL implement FSM states IDLE, CONV, DONE and GAP.
- IDLE -> CONV when en=1.
- CONV -> DONE after 16 bits.
- DONE -> GAP always (1 cycle).
- GAP -> CONV after GAP_CYCLES if en=1, else GAP -> IDLE.
REQ-014 SHALL drive adc_cs_n low only in CONV and high in every other state.
REQ-015 SHALL form each bit in CONV as CLK_DIV cycles of adc_sclk low followed by CLK_DIV cycles high, so a frame lasts 16 bits x 2*CLK_DIV cycles.
REQ-016 SHALL register adc_sdata once and shift the registered value into a 16-bit shift register on the last clk cycle of each SCLK high half.
REQ-017 SHALL, in DONE, load sample with shift[11:0] and frame_err with OR(shift[15:12]), and pulse sample_valid for exactly that one cycle.
REQ-018 SHALL hold sample, A..D and frame_err stable between sample_valid pulses.
REQ-019 SHALL, when en falls during CONV, complete the frame including DONE and GAP, then enter IDLE; a frame is never truncated.
REQ-020 SHALL, when en falls during GAP, enter IDLE at the end of GAP; an en pulse in IDLE starts exactly one frame or more only while en remains high.
REQ-021 SHALL use a bit counter of 0..15 that clears on entry to CONV, and a half-period counter of 0..CLK_DIV-1 that wraps with no skipped or extra cycles.
REQ-022 SHALL keep frame_err informational only; sample still updates when frame_err=1.

Reset
REQ-023 SHALL, on rst_n low and at any time including mid-frame, immediately force state=IDLE, adc_cs_n=1, adc_sclk=1, sample=0, sample_valid=0, frame_err=0, all counters=0 and shift register=0.
REQ-024 SHALL start its first frame no earlier than the first clk edge after rst_n is released with en=1.

Structure
REQ-025 SHALL place the state enum and the constants FRAME_BITS=16, DATA_BITS=12 and LEAD_BITS=4 in shared package adc_pkg.
REQ-026 SHALL implement SCLK edge/tick generation as sub-module adc_clk_div (parameter CLK_DIV; outputs sclk and sample_tick).

Verification
REQ-027 SHALL cover: CLK_DIV=2, en=1, serial 0x0B00 -> sample=0xB00, A=1, B=0, C=1, D=1, frame_err=0, sample_valid 1 cycle, 64 cycles after adc_cs_n falls.
REQ-028 SHALL cover: serial 0xF123 -> sample=0x123, frame_err=1, A..D=0001.
REQ-029 SHALL cover: en held high for 3 frames -> gaps between adc_cs_n rise and next fall of exactly GAP_CYCLES+1 cycles, with 3 sample_valid pulses.
REQ-030 SHALL cover: en dropped at bit 5 -> frame completes, valid pulses once, then IDLE with adc_cs_n=1 and adc_sclk=1.
REQ-031 SHALL cover: rst_n asserted at bit 9 -> same cycle adc_cs_n=1, adc_sclk=1, sample=0; after release with en=1 a fresh full 16-bit frame is captured correctly.
REQ-032 SHALL cover: adc_sclk checked against CLK_DIV=4 -> every half-period is exactly 4 cycles and there are 16 rising edges per frame.
